axi_lite_master_bridge: RTL

Single-outstanding AXI4-Lite master that converts a simple valid/ready command/response interface into AXI4-Lite read and write transactions. It is the initiator-side counterpart to the codebase's AXI4-Lite slave peripherals, such as the GPIO controller. It is used by test sequencers, small control FSMs and debug bridges that drive register-mapped IP.

---
 rtl/axi_lite_master_bridge.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_master_bridge.sv
// axi_lite_master_bridge
//   Single-outstanding AXI4-Lite master. Converts a valid/ready command /
//   response pair into one AXI4-Lite read or write transaction at a time.
//   Optional feature macro: AXIL_MASTER_LATENCY_EN
//     defined   -> rsp_latency reports issue-to-completion cycles (saturating)
//     undefined -> rsp_latency is tied to zero
module axi_lite_master_bridge #(
  parameter int          ADDR_WIDTH = 4,
  parameter logic [2:0]  PROT       = 3'b000
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  // command side
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_wdata,
  input  logic [3:0]            cmd_wstrb,
  // response side
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [31:0]           rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [15:0]           rsp_latency,
  // AXI4-Lite write address channel
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  // AXI4-Lite write data channel
  output logic [31:0]           m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  // AXI4-Lite write response channel
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  // AXI4-Lite read address channel
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  // AXI4-Lite read data channel
  input  logic [31:0]           m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RESP
  } state_t;

  state_t state_q, state_d;
  logic   cmd_hs;
  logic   wr_q;

  assign cmd_hs       = cmd_valid & cmd_ready;
  assign m_axi_awprot = PROT;
  assign m_axi_arprot = PROT;

  // State register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state and state-decoded handshake outputs.
  // WR_ADDR_DATA leaves only once both registered valids have dropped, so the
  // exit is decided from settled flags rather than from the handshake edges.
  always_comb begin
    state_d      = state_q;
    cmd_ready    = 1'b0;
    m_axi_bready = 1'b0;
    m_axi_rready = 1'b0;
    rsp_valid    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = aresetn;
        if (cmd_valid && aresetn) state_d = cmd_write ? WR_ADDR_DATA : RD_ADDR;
      end
      WR_ADDR_DATA: begin
        if (!m_axi_awvalid && !m_axi_wvalid) state_d = WR_RESP;
      end
      WR_RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_d = RESP;
      end
      RD_ADDR: begin
        if (m_axi_arvalid && m_axi_arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Command latch and AXI request channels; payload only changes on accept
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_q          <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_araddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_arvalid <= 1'b0;
    end else begin
      if (cmd_hs) begin
        wr_q <= cmd_write;
        if (cmd_write) begin
          m_axi_awaddr  <= cmd_addr;
          m_axi_wdata   <= cmd_wdata;
          m_axi_wstrb   <= cmd_wstrb;
          m_axi_awvalid <= 1'b1;
          m_axi_wvalid  <= 1'b1;
        end else begin
          m_axi_araddr  <= cmd_addr;
          m_axi_arvalid <= 1'b1;
        end
      end
      if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
      if (m_axi_wvalid  && m_axi_wready)  m_axi_wvalid  <= 1'b0;
      if (m_axi_arvalid && m_axi_arready) m_axi_arvalid <= 1'b0;
    end
  end

  // Response capture on the b/r handshake; held until the next response
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= '0;
    end else if (state_q == WR_RESP && m_axi_bvalid) begin
      rsp_write <= wr_q;
      rsp_rdata <= '0;
      rsp_resp  <= m_axi_bresp;
    end else if (state_q == RD_DATA && m_axi_rvalid) begin
      rsp_write <= wr_q;
      rsp_rdata <= m_axi_rdata;
      rsp_resp  <= m_axi_rresp;
    end
  end

`ifdef AXIL_MASTER_LATENCY_EN
  logic [15:0] lat_cnt;
  logic [15:0] lat_next;
  logic        busy;

  // Saturating increment and busy-state decode
  always_comb begin
    lat_next = (lat_cnt == 16'hFFFF) ? lat_cnt : lat_cnt + 16'd1;
    busy     = (state_q == WR_ADDR_DATA) || (state_q == WR_RESP) ||
               (state_q == RD_ADDR)      || (state_q == RD_DATA);
  end

  // Cycle counter: cleared on accept, counts every in-flight cycle.
  // The published value includes the final in-flight cycle, hence lat_next.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lat_cnt     <= '0;
      rsp_latency <= '0;
    end else begin
      if (cmd_hs)    lat_cnt <= '0;
      else if (busy) lat_cnt <= lat_next;
      if (busy && state_d == RESP) rsp_latency <= lat_next;
    end
  end
`else
  assign rsp_latency = '0;
`endif

endmodule
